// File: rtl/opb_master_pkg.sv
// Shared types for the OPB master bridge: FSM states, byte-enable width and
// the slave-response priority decode used while a transfer is in flight.
package opb_master_pkg;

  localparam int BE_W = 4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ     = 3'd1,
    XFER    = 3'd2,
    BACKOFF = 3'd3,
    RESP    = 3'd4
  } state_e;

  typedef enum logic [2:0] {
    XR_WAIT    = 3'd0,
    XR_TIMEOUT = 3'd1,
    XR_ERR     = 3'd2,
    XR_RETRY   = 3'd3,
    XR_ACK     = 3'd4
  } xfer_rsp_e;

  // Timeout beats errAck beats retry beats xferAck.
  function automatic xfer_rsp_e xfer_rsp_decode(input logic timeout,
                                                input logic errack,
                                                input logic retry,
                                                input logic xferack);
    xfer_rsp_e r;
    if (timeout) begin
      r = XR_TIMEOUT;
    end else if (errack) begin
      r = XR_ERR;
    end else if (retry) begin
      r = XR_RETRY;
    end else if (xferack) begin
      r = XR_ACK;
    end else begin
      r = XR_WAIT;
    end
    return r;
  endfunction

endpackage

// File: rtl/opb_master_bridge.sv
// Single-outstanding OPB master driven by a valid/ready command port.
// Optional build macro RETRY_LIMIT_EN bounds the number of slave retries.
module opb_master_bridge
  import opb_master_pkg::*;
#(
  parameter int C_OPB_AWIDTH = 32,
  parameter int C_OPB_DWIDTH = 32,
  parameter int C_MAX_RETRY  = 15
) (
  input  logic                    OPB_Clk,
  input  logic                    OPB_Rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_rnw,
  input  logic [C_OPB_AWIDTH-1:0] cmd_addr,
  input  logic [BE_W-1:0]         cmd_be,
  input  logic [C_OPB_DWIDTH-1:0] cmd_wdata,
  output logic                    rsp_valid,
  output logic [C_OPB_DWIDTH-1:0] rsp_rdata,
  output logic                    rsp_err,
  output logic                    M_request,
  output logic                    M_select,
  output logic                    M_RNW,
  output logic [C_OPB_AWIDTH-1:0] M_ABus,
  output logic [BE_W-1:0]         M_BE,
  output logic [C_OPB_DWIDTH-1:0] M_DBus,
  output logic                    M_seqAddr,
  input  logic                    OPB_MGrant,
  input  logic                    OPB_xferAck,
  input  logic                    OPB_errAck,
  input  logic                    OPB_retry,
  input  logic                    OPB_timeout,
  input  logic [C_OPB_DWIDTH-1:0] OPB_DBus
);

  state_e                    state_r;
  logic                      rnw_r;
  logic [C_OPB_AWIDTH-1:0]   addr_r;
  logic [BE_W-1:0]           be_r;
  logic [C_OPB_DWIDTH-1:0]   wdata_r;
  xfer_rsp_e                 rsp_kind_s;
  logic                      retry_exhausted_s;

  assign rsp_kind_s = xfer_rsp_decode(OPB_timeout, OPB_errAck, OPB_retry, OPB_xferAck);
  assign M_seqAddr  = 1'b0;

`ifdef RETRY_LIMIT_EN
  localparam logic [3:0] MAX_RETRY = 4'(C_MAX_RETRY);
  logic [3:0] retry_cnt_r;

  assign retry_exhausted_s = ((retry_cnt_r + 4'd1) == MAX_RETRY);

  // Retry counter: cleared on command accept, bumped on every retry seen in XFER.
  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) begin
      retry_cnt_r <= 4'd0;
    end else if (state_r == IDLE && cmd_valid && cmd_ready) begin
      retry_cnt_r <= 4'd0;
    end else if (state_r == XFER && rsp_kind_s == XR_RETRY) begin
      retry_cnt_r <= retry_cnt_r + 4'd1;
    end else begin
      retry_cnt_r <= retry_cnt_r;
    end
  end
`else
  assign retry_exhausted_s = 1'b0;
`endif

  // Bridge FSM; every bus and fabric output is registered from the next state.
  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) begin
      state_r   <= IDLE;
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      M_request <= 1'b0;
      M_select  <= 1'b0;
      M_RNW     <= 1'b0;
      M_ABus    <= '0;
      M_BE      <= '0;
      M_DBus    <= '0;
      rnw_r     <= 1'b0;
      addr_r    <= '0;
      be_r      <= '0;
      wdata_r   <= '0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      case (state_r)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            rnw_r     <= cmd_rnw;
            addr_r    <= cmd_addr;
            be_r      <= cmd_be;
            wdata_r   <= cmd_wdata;
            cmd_ready <= 1'b0;
            M_request <= 1'b1;
            state_r   <= REQ;
          end else begin
            cmd_ready <= 1'b1;
          end
        end
        REQ: begin
          if (OPB_MGrant) begin
            M_request <= 1'b0;
            M_select  <= 1'b1;
            M_RNW     <= rnw_r;
            M_ABus    <= addr_r;
            M_BE      <= be_r;
            M_DBus    <= rnw_r ? '0 : wdata_r;
            state_r   <= XFER;
          end else begin
            M_request <= 1'b1;
          end
        end
        XFER: begin
          if (rsp_kind_s != XR_WAIT) begin
            M_select <= 1'b0;
            M_RNW    <= 1'b0;
            M_ABus   <= '0;
            M_BE     <= '0;
            M_DBus   <= '0;
          end
          case (rsp_kind_s)
            XR_TIMEOUT, XR_ERR: begin
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              state_r   <= RESP;
            end
            XR_RETRY: begin
              if (retry_exhausted_s) begin
                rsp_valid <= 1'b1;
                rsp_err   <= 1'b1;
                state_r   <= RESP;
              end else begin
                state_r   <= BACKOFF;
              end
            end
            XR_ACK: begin
              rsp_valid <= 1'b1;
              if (rnw_r) begin
                rsp_rdata <= OPB_DBus;
              end
              state_r <= RESP;
            end
            default: begin
              state_r <= XFER;
            end
          endcase
        end
        BACKOFF: begin
          M_request <= 1'b1;
          state_r   <= REQ;
        end
        RESP: begin
          cmd_ready <= 1'b1;
          state_r   <= IDLE;
        end
        default: begin
          cmd_ready <= 1'b1;
          M_request <= 1'b0;
          M_select  <= 1'b0;
          M_RNW     <= 1'b0;
          M_ABus    <= '0;
          M_BE      <= '0;
          M_DBus    <= '0;
          state_r   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_opb_master_bridge.sv
// Self-checking bench for opb_master_bridge: directed cases plus randomized
// transactions against a transaction-level expectation model.
module tb_opb_master_bridge;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int MAXR = 2;

  logic          OPB_Clk = 1'b0;
  logic          OPB_Rst;
  logic          cmd_valid, cmd_ready, cmd_rnw;
  logic [AW-1:0] cmd_addr;
  logic [3:0]    cmd_be;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid, rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic          M_request, M_select, M_RNW, M_seqAddr;
  logic [AW-1:0] M_ABus;
  logic [3:0]    M_BE;
  logic [DW-1:0] M_DBus;
  logic          OPB_MGrant, OPB_xferAck, OPB_errAck, OPB_retry, OPB_timeout;
  logic [DW-1:0] OPB_DBus;

  int errors = 0;
  int checks = 0;
  logic [DW-1:0] model_rdata;

  always #5 OPB_Clk = ~OPB_Clk;

  opb_master_bridge #(.C_OPB_AWIDTH(AW), .C_OPB_DWIDTH(DW), .C_MAX_RETRY(MAXR)) dut (
    .OPB_Clk(OPB_Clk), .OPB_Rst(OPB_Rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rnw(cmd_rnw),
    .cmd_addr(cmd_addr), .cmd_be(cmd_be), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .M_request(M_request), .M_select(M_select), .M_RNW(M_RNW),
    .M_ABus(M_ABus), .M_BE(M_BE), .M_DBus(M_DBus), .M_seqAddr(M_seqAddr),
    .OPB_MGrant(OPB_MGrant), .OPB_xferAck(OPB_xferAck), .OPB_errAck(OPB_errAck),
    .OPB_retry(OPB_retry), .OPB_timeout(OPB_timeout), .OPB_DBus(OPB_DBus)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_slave();
    OPB_MGrant  = 1'b0;
    OPB_xferAck = 1'b0;
    OPB_errAck  = 1'b0;
    OPB_retry   = 1'b0;
    OPB_timeout = 1'b0;
  endtask

  task automatic check_bus_idle(input string tag);
    check({tag, "_request"}, 64'(M_request), 64'd0);
    check({tag, "_select"},  64'(M_select),  64'd0);
    check({tag, "_bus"}, {M_RNW, M_BE, M_ABus, M_seqAddr}, 64'd0);
    check({tag, "_dbus"},    64'(M_DBus),    64'd0);
  endtask

  // fkind: 0 = xferAck, 1 = errAck, 2 = errAck+xferAck, 3 = timeout (maybe with acks)
  task automatic txn(input logic rnw, input logic [AW-1:0] addr, input logic [3:0] be,
                     input logic [DW-1:0] wd, input int gdel, input int xdel,
                     input int nretry, input int fkind);
    bit done = 1'b0;
    int r = 0;
    bit is_retry, limit_hit;
    logic exp_err;
    logic [DW-1:0] rd;
    @(negedge OPB_Clk);
    check("accept_ready", 64'(cmd_ready), 64'd1);
    cmd_valid = 1'b1; cmd_rnw = rnw; cmd_addr = addr; cmd_be = be; cmd_wdata = wd;
    @(posedge OPB_Clk);
    @(negedge OPB_Clk);
    cmd_valid = 1'b0; cmd_rnw = ~rnw; cmd_addr = $urandom; cmd_be = 4'($urandom); cmd_wdata = $urandom;
    while (!done) begin
      for (int g = 0; g <= gdel; g++) begin
        if (g > 0) @(negedge OPB_Clk);
        check("req_request", 64'(M_request), 64'd1);
        check("req_select",  64'(M_select),  64'd0);
        check("req_abus",    64'(M_ABus),    64'd0);
        check("req_ready",   64'(cmd_ready), 64'd0);
        OPB_MGrant = (g == gdel);
        @(posedge OPB_Clk);
      end
      @(negedge OPB_Clk);
      OPB_MGrant = 1'b0;
      is_retry  = (r < nretry);
`ifdef RETRY_LIMIT_EN
      limit_hit = is_retry && ((r + 1) == MAXR);
`else
      limit_hit = 1'b0;
`endif
      rd = $urandom;
      for (int x = 0; x <= xdel; x++) begin
        if (x > 0) @(negedge OPB_Clk);
        check("xfer_select",  64'(M_select),  64'd1);
        check("xfer_request", 64'(M_request), 64'd0);
        check("xfer_rnw",     64'(M_RNW),     64'(rnw));
        check("xfer_abus",    64'(M_ABus),    64'(addr));
        check("xfer_be",      64'(M_BE),      64'(be));
        check("xfer_dbus",    64'(M_DBus),    rnw ? 64'd0 : 64'(wd));
        check("xfer_rspv",    64'(rsp_valid), 64'd0);
        OPB_DBus = (x == xdel) ? rd : DW'($urandom);
        if (x == xdel) begin
          if (is_retry) begin
            OPB_retry   = 1'b1;
            OPB_xferAck = 1'($urandom_range(0, 1));
          end else begin
            OPB_xferAck = (fkind == 0 || fkind == 2) ? 1'b1 : 1'($urandom_range(0, 1));
            OPB_errAck  = (fkind == 1 || fkind == 2) ? 1'b1 : (fkind == 3 ? 1'($urandom_range(0, 1)) : 1'b0);
            OPB_timeout = (fkind == 3);
            OPB_retry   = (fkind != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
          end
        end
      end
      @(posedge OPB_Clk);
      @(negedge OPB_Clk);
      clear_slave();
      OPB_DBus = $urandom;
      if (is_retry && !limit_hit) begin
        check_bus_idle("backoff");
        check("backoff_rspv", 64'(rsp_valid), 64'd0);
        @(posedge OPB_Clk);
        @(negedge OPB_Clk);
        r++;
      end else begin
        exp_err = limit_hit || (fkind != 0);
        if (!exp_err && rnw) model_rdata = rd;
        check("resp_valid", 64'(rsp_valid), 64'd1);
        check("resp_err",   64'(rsp_err),   64'(exp_err));
        check("resp_rdata", 64'(rsp_rdata), 64'(model_rdata));
        check("resp_ready", 64'(cmd_ready), 64'd0);
        check_bus_idle("resp");
        @(posedge OPB_Clk);
        @(negedge OPB_Clk);
        check("post_ready", 64'(cmd_ready), 64'd1);
        check("post_rspv",  64'(rsp_valid), 64'd0);
        check("post_rdata", 64'(rsp_rdata), 64'(model_rdata));
        done = 1'b1;
      end
    end
  endtask

  initial begin
    OPB_Rst = 1'b1; cmd_valid = 1'b0; cmd_rnw = 1'b0; cmd_addr = '0; cmd_be = '0;
    cmd_wdata = '0; OPB_DBus = '0; model_rdata = '0;
    clear_slave();
    repeat (3) @(posedge OPB_Clk);
    @(negedge OPB_Clk);
    check("rst_ready", 64'(cmd_ready), 64'd1);
    check("rst_rspv",  64'(rsp_valid), 64'd0);
    check("rst_err",   64'(rsp_err),   64'd0);
    check("rst_rdata", 64'(rsp_rdata), 64'd0);
    check_bus_idle("rst");
    OPB_Rst = 1'b0;

    // Directed cases
    txn(1'b0, 32'h0108_0400, 4'hF, 32'hDEAD_BEEF, 0, 0, 0, 0);
    txn(1'b1, 32'h0108_0400, 4'hF, 32'h0000_0000, 3, 2, 0, 0);
    txn(1'b1, 32'h0108_0404, 4'h3, 32'h0000_0000, 0, 0, 0, 2);
    txn(1'b1, 32'h0108_0408, 4'hC, 32'h0000_0000, 1, 0, 2, 0);
    txn(1'b0, 32'h0108_040C, 4'h1, 32'hA5A5_5A5A, 0, 1, 0, 3);
    txn(1'b0, 32'h0108_0410, 4'h2, 32'h1234_0000, 0, 0, 0, 1);

    // Randomized transactions
    for (int i = 0; i < 40; i++) begin
      txn(1'($urandom_range(0, 1)), 32'($urandom), 4'($urandom), 32'($urandom),
          $urandom_range(0, 3), $urandom_range(0, 2),
          ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0,
          ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3));
    end

    // Reset asserted while the transfer is in XFER
    @(negedge OPB_Clk);
    cmd_valid = 1'b1; cmd_rnw = 1'b1; cmd_addr = 32'h0000_1000; cmd_be = 4'hF;
    @(posedge OPB_Clk);
    @(negedge OPB_Clk);
    cmd_valid = 1'b0; OPB_MGrant = 1'b1;
    @(posedge OPB_Clk);
    @(negedge OPB_Clk);
    OPB_MGrant = 1'b0;
    check("mid_select", 64'(M_select), 64'd1);
    OPB_Rst = 1'b1; OPB_xferAck = 1'b1; OPB_DBus = 32'hCAFE_F00D;
    @(posedge OPB_Clk);
    @(negedge OPB_Clk);
    OPB_Rst = 1'b0; clear_slave();
    model_rdata = '0;
    check_bus_idle("midrst");
    check("midrst_ready", 64'(cmd_ready), 64'd1);
    check("midrst_rspv",  64'(rsp_valid), 64'd0);
    check("midrst_rdata", 64'(rsp_rdata), 64'(model_rdata));
    @(negedge OPB_Clk);
    check("midrst_rspv2", 64'(rsp_valid), 64'd0);
    check("midrst_req2",  64'(M_request), 64'd0);
    txn(1'b1, 32'h0000_2000, 4'hF, 32'h0, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
